// File: rtl/dffsr_ctrl_pkg.sv
// Shared definitions for the set/clear flip-flop bank sequencer.
//   - command op encoding (OP_LOAD .. OP_READ)
//   - sequencer FSM state enum
//   - width of the saturating mismatch counter
package dffsr_ctrl_pkg;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_SET  = 2'd1;
    localparam logic [1:0] OP_CLR  = 2'd2;
    localparam logic [1:0] OP_READ = 2'd3;

    localparam int ERR_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PULSE,
        ST_SETTLE,
        ST_CHECK,
        ST_RESP
    } state_e;

endpackage

// File: rtl/dffsr_cyc_timer.sv
// Loadable down-counter used to time the PULSE and SETTLE windows.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset
//   load_i     : reload the counter with load_val_i this cycle
//   load_val_i : number of cycles the window should last
//   done_o     : high in the last cycle of the window
// The counter stops at zero rather than wrapping.
module dffsr_cyc_timer
    import dffsr_ctrl_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/dffsr_ctrl_seq.sv
// Command sequencer driving a WIDTH-bit set/clear flip-flop bank.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o : command handshake
//   cmd_op_i                : LOAD/SET/CLR/READ
//   cmd_mask_i, cmd_data_i  : SET/CLR bit mask, LOAD value
//   d_o, set_o, clr_o       : registered drives to the bank
//   q_i                     : bank output
//   rsp_valid_o/rsp_ready_i : response handshake
//   rsp_q_o, rsp_err_o      : sampled Q and mismatch flag
//   err_cnt_o               : saturating mismatch count
//
// state     | meaning
// ST_IDLE   | ready for a command
// ST_PULSE  | driving D / SET / CLR for PULSE_CYC cycles
// ST_SETTLE | SET/CLR released, waiting SETTLE_CYC cycles
// ST_CHECK  | sample Q and compare against expected
// ST_RESP   | response held until consumed
module dffsr_ctrl_seq
    import dffsr_ctrl_pkg::*;
#(
    parameter int WIDTH      = 2,
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [1:0]           cmd_op_i,
    input  logic [WIDTH-1:0]     cmd_mask_i,
    input  logic [WIDTH-1:0]     cmd_data_i,
    output logic [WIDTH-1:0]     d_o,
    output logic [WIDTH-1:0]     set_o,
    output logic [WIDTH-1:0]     clr_o,
    input  logic [WIDTH-1:0]     q_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [WIDTH-1:0]     rsp_q_o,
    output logic                 rsp_err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    localparam int MAX_CYC = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    state_e                 state_q, state_d;
    logic [1:0]             op_q, op_d;
    logic [WIDTH-1:0]       mask_q, mask_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic [WIDTH-1:0]       qb_q, qb_d;
    logic [WIDTH-1:0]       d_q, d_d;
    logic [WIDTH-1:0]       set_q, set_d;
    logic [WIDTH-1:0]       clr_q, clr_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]       rsp_q_q, rsp_q_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0]       exp_val;
    logic                   tmr_load, tmr_done;
    logic [CNT_W-1:0]       tmr_val;

    dffsr_cyc_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_comb begin
        case (op_q)
            OP_LOAD: exp_val = data_q;
            OP_SET:  exp_val = qb_q | mask_q;
            OP_CLR:  exp_val = qb_q & ~mask_q;
            default: exp_val = qb_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        mask_d    = mask_q;
        data_d    = data_q;
        qb_d      = qb_q;
        rsp_q_d   = rsp_q_q;
        rsp_err_d = rsp_err_q;
        err_cnt_d = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                // cmd_ready_q is still low on the first cycle out of reset
                if (cmd_valid_i && cmd_ready_q) begin
                    op_d    = cmd_op_i;
                    mask_d  = cmd_mask_i;
                    data_d  = cmd_data_i;
                    qb_d    = q_i;
                    state_d = (cmd_op_i == OP_READ) ? ST_CHECK : ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (tmr_done) begin
                    state_d = (SETTLE_CYC == 0) ? ST_CHECK : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (tmr_done) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                rsp_q_d   = q_i;
                rsp_err_d = (q_i != exp_val);
                if ((q_i != exp_val) && (err_cnt_q != '1)) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        set_d       = (state_d == ST_PULSE && op_d == OP_SET) ? mask_d : '0;
        clr_d       = (state_d == ST_PULSE && op_d == OP_CLR) ? mask_d : '0;
        d_d         = (state_d == ST_PULSE && op_d == OP_LOAD) ? data_d : d_q;
        cmd_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);

        tmr_load = (state_d != state_q);
        if (state_d == ST_PULSE) begin
            tmr_val = CNT_W'(PULSE_CYC);
        end else if (state_d == ST_SETTLE) begin
            tmr_val = CNT_W'(SETTLE_CYC);
        end else begin
            tmr_val = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            mask_q      <= '0;
            data_q      <= '0;
            qb_q        <= '0;
            d_q         <= '0;
            set_q       <= '0;
            clr_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q_q     <= '0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mask_q      <= mask_d;
            data_q      <= data_d;
            qb_q        <= qb_d;
            d_q         <= d_d;
            set_q       <= set_d;
            clr_q       <= clr_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q_q     <= rsp_q_d;
            rsp_err_q   <= rsp_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign d_o         = d_q;
    assign set_o       = set_q;
    assign clr_o       = clr_q;
    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_q_o     = rsp_q_q;
    assign rsp_err_o   = rsp_err_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_dffsr_ctrl_seq.sv
// Bench for dffsr_ctrl_seq: behavioural flip-flop bank, a value-level
// reference model feeding a scoreboard queue, and a response monitor.
module tb_dffsr_ctrl_seq;
    import dffsr_ctrl_pkg::*;

    localparam int W = 2;
    localparam int P = 2;
    localparam int S = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = '0;
    logic [W-1:0] cmd_mask = '0;
    logic [W-1:0] cmd_data = '0;
    logic [W-1:0] d_o, set_o, clr_o;
    logic [W-1:0] bank_q = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_q;
    logic         rsp_err;
    logic [7:0]   err_cnt;

    always #5 clk = ~clk;

    dffsr_ctrl_seq #(.WIDTH(W), .PULSE_CYC(P), .SETTLE_CYC(S)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_mask_i  (cmd_mask),
        .cmd_data_i  (cmd_data),
        .d_o         (d_o),
        .set_o       (set_o),
        .clr_o       (clr_o),
        .q_i         (bank_q),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_q_o     (rsp_q),
        .rsp_err_o   (rsp_err),
        .err_cnt_o   (err_cnt)
    );

    // Flip-flop bank: captures D on the edge after a LOAD is accepted,
    // per-bit clear/set otherwise; "stuck" forces the outputs to zero.
    logic ld_pend = 1'b0;
    bit   stuck = 1'b0;
    always @(posedge clk) begin
        ld_pend <= cmd_valid && cmd_ready && (cmd_op == OP_LOAD) && !rst;
        bank_q  <= stuck ? '0 : ((((ld_pend ? d_o : bank_q) & ~clr_o)) | set_o);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] mask;
        logic [W-1:0] q;
        logic         err;
        logic [7:0]   cnt;
        logic [W-1:0] d;
        int           lat;
        int           k;
    } exp_t;
    exp_t sb[$];

    // Reference model: value held by the bank, last LOAD data, error count.
    logic [W-1:0] model_q = '0;
    logic [W-1:0] model_d = '0;
    int           model_cnt = 0;

    bit hold_rdy = 1'b0;
    always begin
        @(posedge clk);
        #2;
        if (!hold_rdy) rsp_ready = ($urandom % 4) != 0;
    end

    // Response monitor
    int           set_cyc = 0, clr_cyc = 0, first_cyc = 0;
    logic [W-1:0] set_or = '0, clr_or = '0;
    bit           seen = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            set_cyc = 0; clr_cyc = 0; set_or = '0; clr_or = '0; seen = 1'b0;
        end else begin
            chk("set_clr_exclusive", int'((set_o != '0) && (clr_o != '0)), 0);
            if (set_o != '0) set_cyc++;
            if (clr_o != '0) clr_cyc++;
            set_or = set_or | set_o;
            clr_or = clr_or | clr_o;
            if (rsp_valid && !seen) begin
                seen = 1'b1;
                first_cyc = cyc;
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_q", int'(rsp_q), int'(e.q));
                    chk("rsp_err", int'(rsp_err), int'(e.err));
                    chk("err_cnt", int'(err_cnt), int'(e.cnt));
                    chk("d_hold", int'(d_o), int'(e.d));
                    chk("latency", first_cyc - e.k, e.lat);
                    chk("cmd_ready_busy", int'(cmd_ready), 0);
                    chk("set_width", set_cyc, (e.op == OP_SET && e.mask != '0) ? P : 0);
                    chk("clr_width", clr_cyc, (e.op == OP_CLR && e.mask != '0) ? P : 0);
                    chk("set_value", int'(set_or), (e.op == OP_SET) ? int'(e.mask) : 0);
                    chk("clr_value", int'(clr_or), (e.op == OP_CLR) ? int'(e.mask) : 0);
                end
                set_cyc = 0; clr_cyc = 0; set_or = '0; clr_or = '0; seen = 1'b0;
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [W-1:0] mask, input logic [W-1:0] data);
        int guard = 0;
        exp_t e;
        logic [W-1:0] ex;
        logic [W-1:0] act;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_mask = mask; cmd_data = data;
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        case (op)
            OP_LOAD: ex = data;
            OP_SET:  ex = model_q | mask;
            OP_CLR:  ex = model_q & ~mask;
            default: ex = model_q;
        endcase
        act = stuck ? '0 : ex;
        if (act != ex && model_cnt < 255) model_cnt++;
        if (op == OP_LOAD) model_d = data;
        e.op = op; e.mask = mask; e.q = act; e.err = (act != ex);
        e.cnt = 8'(model_cnt); e.d = model_d;
        e.lat = (op == OP_READ) ? 1 : P + S + 1;
        e.k = cyc + 1;
        sb.push_back(e);
        model_q = act;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((sb.size() != 0 || !cmd_ready) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_timeout", int'(sb.size() == 0 && cmd_ready), 1);
    endtask

    task automatic set_stuck(input bit v);
        drain();
        stuck = v;
        @(negedge clk);
        if (v) model_q = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int guard;
        // Reset held three cycles
        repeat (3) begin
            @(negedge clk);
            chk("rst_cmd_ready", int'(cmd_ready), 0);
            chk("rst_outputs", int'({d_o, set_o, clr_o}), 0);
            chk("rst_rsp_valid", int'(rsp_valid), 0);
        end
        chk("rst_err_cnt", int'(err_cnt), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(cmd_ready), 1);

        // Directed functional cases
        issue(OP_LOAD, 2'b00, 2'b10);
        issue(OP_LOAD, 2'b00, 2'b00);
        issue(OP_SET,  2'b01, 2'b00);
        issue(OP_CLR,  2'b01, 2'b00);
        issue(OP_SET,  2'b00, 2'b11);
        issue(OP_READ, 2'b00, 2'b00);

        // Stuck bank: single error then saturation
        set_stuck(1'b1);
        issue(OP_SET, 2'b11, 2'b00);
        for (int i = 0; i < 300; i++) issue(OP_LOAD, 2'b00, 2'b11);
        drain();
        chk("err_cnt_saturated", int'(err_cnt), 255);
        set_stuck(1'b0);

        // Back-pressure on the response
        drain();
        hold_rdy = 1'b1;
        rsp_ready = 1'b0;
        issue(OP_LOAD, 2'b00, 2'b01);
        guard = 0;
        while (!rsp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        repeat (5) begin
            chk("hold_rsp_valid", int'(rsp_valid), 1);
            chk("hold_rsp_q", int'(rsp_q), 1);
            chk("hold_cmd_ready", int'(cmd_ready), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #2 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ready_after_release", int'(cmd_ready), 1);
        chk("valid_after_release", int'(rsp_valid), 0);
        hold_rdy = 1'b0;

        // Reset in the middle of a CLR pulse
        drain();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_CLR; cmd_mask = 2'b11; cmd_data = '0;
        @(posedge clk);
        #2 cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_clr_pulse", int'(clr_o), 3);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("abort_clr_zero", int'(clr_o), 0);
        chk("abort_set_zero", int'(set_o), 0);
        chk("abort_d_zero", int'(d_o), 0);
        model_q = model_q & ~2'b11;
        model_d = '0;
        model_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            chk("abort_no_rsp", int'(rsp_valid), 0);
        end
        issue(OP_READ, 2'b00, 2'b00);

        // Randomized traffic with occasional stuck-bank windows
        for (int i = 0; i < 150; i++) begin
            if ($urandom % 12 == 0) set_stuck(!stuck);
            issue(2'($urandom % 4), 2'($urandom % 4), 2'($urandom % 4));
        end
        set_stuck(1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
